// File: rtl/modinv_round_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : modinv_round_scheduler_pkg
// Purpose  : Shared constants for the modular-inversion round scheduler and
//            its precalc/update helpers. It holds the FSM state codes, the
//            update_sel case codes and the clog2 helper used to size the
//            round counter.
// Revision : 1.0 - initial release
// ============================================================================
package modinv_round_scheduler_pkg;

  typedef logic [2:0] state_t;
  typedef logic [1:0] upd_sel_t;

  // Scheduler FSM state encodings
  localparam state_t c_ST_IDLE      = 3'd0;
  localparam state_t c_ST_PRE_START = 3'd1;
  localparam state_t c_ST_PRE_WAIT  = 3'd2;
  localparam state_t c_ST_DECIDE    = 3'd3;
  localparam state_t c_ST_UPD_START = 3'd4;
  localparam state_t c_ST_UPD_WAIT  = 3'd5;

  // Update helper case select; the helper decodes these same codes
  localparam upd_sel_t c_SEL_U_HALF = 2'd0;  // u=u/2,     s=2s
  localparam upd_sel_t c_SEL_V_HALF = 2'd1;  // v=v/2,     r=2r
  localparam upd_sel_t c_SEL_U_SUB  = 2'd2;  // u=(u-v)/2, r=r+s, s=2s
  localparam upd_sel_t c_SEL_V_SUB  = 2'd3;  // v=(v-u)/2, s=r+s, r=2r

  // Ceiling log2; mi_clog2(n) bits can represent the values 0..n-1
  function automatic int mi_clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // The round limit for an operand of the given number of 32-bit words
  function automatic int mi_max_rounds(input int num_words);
    return 64 * num_words;
  endfunction

endpackage
`default_nettype wire

// File: rtl/modinv_round_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : modinv_round_scheduler_if
// Purpose  : Bundle of the scheduler's control and status signals.
//   ena/rdy/k/err              : start request, idle flag, round count, error
//   precalc_ena/precalc_rdy    : precalc helper start pulse / idle flag
//   update_ena/update_rdy      : update helper start pulse / idle flag
//   update_sel                 : update helper case select
//   u_lsb/v_lsb/u_lt_v/v_is_zero : operand status flags
//   modport master : the scheduler side; modport slave : the environment side
// Revision : 1.0 - initial release
// ============================================================================
interface modinv_round_scheduler_if
  import modinv_round_scheduler_pkg::*;
#(
  parameter int K_BITS = mi_clog2(mi_max_rounds(9) + 1)
);
  logic              ena;
  logic              rdy;
  logic [K_BITS-1:0] k;
  logic              err;
  logic              precalc_ena;
  logic              precalc_rdy;
  logic              update_ena;
  logic              update_rdy;
  logic [1:0]        update_sel;
  logic              u_lsb;
  logic              v_lsb;
  logic              u_lt_v;
  logic              v_is_zero;

  modport master (
    input  ena, precalc_rdy, update_rdy, u_lsb, v_lsb, u_lt_v, v_is_zero,
    output rdy, k, err, precalc_ena, update_ena, update_sel
  );

  modport slave (
    output ena, precalc_rdy, update_rdy, u_lsb, v_lsb, u_lt_v, v_is_zero,
    input  rdy, k, err, precalc_ena, update_ena, update_sel
  );
endinterface
`default_nettype wire

// File: rtl/modinv_round_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : modinv_round_scheduler
// Purpose  : Sequences the rounds of an almost-Montgomery-inverse (Kaliski)
//            computation. Each round starts the precalc helper, waits for it,
//            picks one of four update cases from the operand flags, starts
//            the update helper, waits for it and counts the round in k.
//            The run ends when v reaches zero (err=0) or when k reaches
//            MAX_ROUNDS (err=1).
// Ports    : clk   - single clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - control/status bundle (master modport)
// Revision : 1.0 - initial release
// ============================================================================
module modinv_round_scheduler
  import modinv_round_scheduler_pkg::*;
#(
  parameter int BUFFER_NUM_WORDS = 9,
  parameter int K_BITS           = mi_clog2(mi_max_rounds(BUFFER_NUM_WORDS) + 1)
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  modinv_round_scheduler_if.master bus
);

  localparam int                MAX_ROUNDS = mi_max_rounds(BUFFER_NUM_WORDS);
  localparam logic [K_BITS-1:0] c_MAX_K    = K_BITS'(MAX_ROUNDS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [K_BITS-1:0] r_k;
  logic              r_err;
  upd_sel_t          r_update_sel;
  upd_sel_t          w_dec_sel;
  logic              w_at_limit;
  logic              w_rdy;
  logic              w_precalc_ena;
  logic              w_update_ena;

  assign w_at_limit = (r_k == c_MAX_K);

  // Update case from the operand flags; only registered while in DECIDE
  always_comb begin
    w_dec_sel = c_SEL_V_SUB;
    if (!bus.u_lsb)       w_dec_sel = c_SEL_U_HALF;
    else if (!bus.v_lsb)  w_dec_sel = c_SEL_V_HALF;
    else if (!bus.u_lt_v) w_dec_sel = c_SEL_U_SUB;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:      if (bus.ena) w_state_nxt = c_ST_PRE_START;
      c_ST_PRE_START: w_state_nxt = c_ST_PRE_WAIT;
      c_ST_PRE_WAIT:  if (bus.precalc_rdy) w_state_nxt = c_ST_DECIDE;
      c_ST_DECIDE: begin
        if (bus.v_is_zero || w_at_limit) w_state_nxt = c_ST_IDLE;
        else                             w_state_nxt = c_ST_UPD_START;
      end
      c_ST_UPD_START: w_state_nxt = c_ST_UPD_WAIT;
      c_ST_UPD_WAIT:  if (bus.update_rdy) w_state_nxt = c_ST_PRE_START;
      default:        w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Outputs decoded from the state alone, so the reset value of the state
  // register forces rdy=1 and both enables low immediately
  always_comb begin
    w_rdy         = (r_state == c_ST_IDLE);
    w_precalc_ena = (r_state == c_ST_PRE_START);
    w_update_ena  = (r_state == c_ST_UPD_START);
  end

  // Round counter, error flag and held update select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k          <= '0;
      r_err        <= 1'b0;
      r_update_sel <= c_SEL_U_HALF;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (bus.ena) begin
            r_k   <= '0;
            r_err <= 1'b0;
          end
        end
        c_ST_DECIDE: begin
          if (bus.v_is_zero)  r_err        <= 1'b0;
          else if (w_at_limit) r_err       <= 1'b1;
          else                r_update_sel <= w_dec_sel;
        end
        // DECIDE stops the run at the limit, so this never wraps
        c_ST_UPD_WAIT: if (bus.update_rdy) r_k <= r_k + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.rdy         = w_rdy;
  assign bus.k           = r_k;
  assign bus.err         = r_err;
  assign bus.precalc_ena = w_precalc_ena;
  assign bus.update_ena  = w_update_ena;
  assign bus.update_sel  = r_update_sel;

endmodule
`default_nettype wire
